// File: rtl/cache_types.sv
// Shared coherence-bus message types and the arbiter state encoding.
package cache_types;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  src;
    } req_msg_t;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] data;
        logic [3:0]  dst;
    } resp_msg_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit scanning upward from last+1.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 found,
    output logic [$clog2(N)-1:0] winner
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [IW:0]    start_s;
    logic [IW:0]    sum_s;
    logic [IW-1:0]  idx_s;

    // Rotate the doubled vector so last+1 lands at bit 0, then take the lowest set bit.
    always_comb begin
        start_s = {1'b0, last} + (IW+1)'(1);
        dbl_s   = {req, req};
        rot_s   = N'(dbl_s >> start_s);
        found   = |rot_s;
        idx_s   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_s = rot_s[i] ? IW'(i) : idx_s;
        end
        sum_s = start_s + {1'b0, idx_s};
        if (sum_s >= (IW+1)'(N)) begin
            winner = IW'(sum_s - (IW+1)'(N));
        end else begin
            winner = IW'(sum_s);
        end
    end

endmodule

// File: rtl/req_bus_arbiter.sv
// Round-robin owner of the shared snooping request bus; broadcasts the owner's message.
module req_bus_arbiter
    import cache_types::*;
#(
    parameter int  N_REQ       = 4,
    parameter int  GNT_TIMEOUT = 15,
    parameter type msg_t       = req_msg_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         busy,
    input  msg_t [N_REQ-1:0]         tx,
    output logic [N_REQ-1:0]         gnt,
    output msg_t                     req_bus_msg,
    output logic                     req_bus_valid,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     arb_err
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(GNT_TIMEOUT + 1);

    arb_state_t       state_r, next_state_s;
    logic [IW-1:0]    owner_r, owner_nxt_s;
    logic [IW-1:0]    last_r, last_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
    logic             err_r, err_nxt_s;
    logic             pick_found_s;
    logic [IW-1:0]    pick_idx_s;
    logic             own_busy_s;
    logic             own_req_s;
    logic             stray_busy_s;

    rr_picker #(.N(N_REQ)) u_picker (
        .req    (req),
        .last   (last_r),
        .found  (pick_found_s),
        .winner (pick_idx_s)
    );

    assign own_busy_s   = busy[owner_r];
    assign own_req_s    = req[owner_r];
    // gnt_r is zero outside a grant, so in IDLE every busy bit counts as stray.
    assign stray_busy_s = |(busy & ~gnt_r);

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ARB_IDLE;
            owner_r <= '0;
            last_r  <= IW'(N_REQ - 1);
            cnt_r   <= '0;
            gnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
            cnt_r   <= cnt_nxt_s;
            gnt_r   <= gnt_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state logic: arbitration, handshake tracking, grant timeout.
    always_comb begin
        next_state_s = state_r;
        owner_nxt_s  = owner_r;
        last_nxt_s   = last_r;
        cnt_nxt_s    = cnt_r;
        gnt_nxt_s    = gnt_r;
        err_nxt_s    = err_r | stray_busy_s;
        case (state_r)
            ARB_IDLE: begin
                if (pick_found_s) begin
                    next_state_s = ARB_GRANT;
                    owner_nxt_s  = pick_idx_s;
                    gnt_nxt_s    = N_REQ'(1) << pick_idx_s;
                    cnt_nxt_s    = '0;
                end else begin
                    gnt_nxt_s    = '0;
                    owner_nxt_s  = '0;
                end
            end
            ARB_GRANT: begin
                if (own_busy_s) begin
                    next_state_s = ARB_BUSY;
                end else if (!own_req_s || (cnt_r >= CW'(GNT_TIMEOUT))) begin
                    // Withdrawal and timeout both release; only timeout is an error.
                    err_nxt_s    = err_r | stray_busy_s | own_req_s;
                    next_state_s = ARB_IDLE;
                    last_nxt_s   = owner_r;
                    gnt_nxt_s    = '0;
                    owner_nxt_s  = '0;
                end else begin
                    cnt_nxt_s    = cnt_r + CW'(1);
                end
            end
            ARB_BUSY: begin
                if (!own_busy_s) begin
                    next_state_s = ARB_IDLE;
                    last_nxt_s   = owner_r;
                    gnt_nxt_s    = '0;
                    owner_nxt_s  = '0;
                end else begin
                    next_state_s = ARB_BUSY;
                end
            end
            default: begin
                next_state_s = ARB_IDLE;
                gnt_nxt_s    = '0;
                owner_nxt_s  = '0;
                cnt_nxt_s    = '0;
            end
        endcase
    end

    // Broadcast mux: zero-latency path from the registered owner's busy/tx.
    always_comb begin
        req_bus_valid = (state_r != ARB_IDLE) && own_busy_s;
        if (req_bus_valid) begin
            req_bus_msg = tx[owner_r];
        end else begin
            req_bus_msg = '0;
        end
    end

    assign gnt     = gnt_r;
    assign owner   = owner_r;
    assign arb_err = err_r;

endmodule

// File: tb/tb_req_bus_arbiter.sv
// Directed plus randomized bench for req_bus_arbiter against a behavioural bus model.
module tb_req_bus_arbiter;
    import cache_types::*;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     busy;
    req_msg_t [N-1:0] tx;
    logic [N-1:0]     gnt;
    req_msg_t         req_bus_msg;
    logic             req_bus_valid;
    logic [1:0]       owner;
    logic             arb_err;

    req_bus_arbiter #(.N_REQ(N), .GNT_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .busy          (busy),
        .tx            (tx),
        .gnt           (gnt),
        .req_bus_msg   (req_bus_msg),
        .req_bus_valid (req_bus_valid),
        .owner         (owner),
        .arb_err       (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who holds the bus, whether its transfer started, how long it waited.
    int m_owner;
    int m_last;
    int m_wait;
    bit m_in_tx;
    bit m_err;

    logic [N-1:0] obs_gnt;
    logic [1:0]   obs_owner;
    logic         obs_valid;
    req_msg_t     obs_msg;
    logic         obs_err;

    int o;
    int hi;
    int vcnt;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] r_rand;
    logic [3:0] b_rand;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_wait  = 0;
        m_in_tx = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_release();
        m_last  = m_owner;
        m_owner = -1;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] b);
        logic [N-1:0] own_mask;
        int w;
        own_mask = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        if ((b & ~own_mask) != 4'b0000) m_err = 1'b1;
        if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_wait  = 0;
                m_in_tx = 1'b0;
            end
        end else if (m_in_tx) begin
            if (!b[m_owner]) model_release();
        end else if (b[m_owner]) begin
            m_in_tx = 1'b1;
        end else if (!r[m_owner]) begin
            model_release();
        end else if (m_wait == TMO) begin
            m_err = 1'b1;
            model_release();
        end else begin
            m_wait++;
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] b);
        logic [63:0]  rnd;
        logic [N-1:0] e_gnt;
        logic         e_valid;
        req_msg_t     e_msg;
        req  = r;
        busy = b;
        for (int i = 0; i < N; i++) begin
            rnd   = {$urandom(), $urandom()};
            tx[i] = rnd[$bits(req_msg_t)-1:0];
        end
        #2;
        obs_gnt   = gnt;
        obs_owner = owner;
        obs_valid = req_bus_valid;
        obs_msg   = req_bus_msg;
        obs_err   = arb_err;
        e_gnt   = 4'b0000;
        e_valid = 1'b0;
        e_msg   = '0;
        if (m_owner >= 0) begin
            e_gnt   = 4'b0001 << m_owner;
            e_valid = b[m_owner];
            if (e_valid) e_msg = tx[m_owner];
        end
        chk("gnt",   64'(obs_gnt),   64'(e_gnt));
        chk("owner", 64'(obs_owner), (m_owner >= 0) ? 64'(m_owner) : 64'd0);
        chk("valid", 64'(obs_valid), 64'(e_valid));
        chk("msg",   64'(obs_msg),   64'(e_msg));
        chk("err",   64'(obs_err),   64'(m_err));
        model_step(r, b);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        req  = 4'b0000;
        busy = 4'b0000;
        rst  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        busy = 4'b0000;
        tx   = '0;
        model_reset();
        #3;
        chk("rst_gnt",   64'(gnt),           64'd0);
        chk("rst_owner", 64'(owner),         64'd0);
        chk("rst_valid", 64'(req_bus_valid), 64'd0);
        chk("rst_msg",   64'(req_bus_msg),   64'd0);
        chk("rst_err",   64'(arb_err),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single requester with a three-cycle transfer.
        cyc(4'b0100, 4'b0000);
        chk("lat_no_same_cycle", 64'(obs_gnt), 64'd0);
        vcnt = 0;
        cyc(4'b0000, 4'b0100);
        chk("lat_gnt", 64'(obs_gnt), 64'b0100);
        if (obs_valid && obs_msg === tx[2]) vcnt++;
        cyc(4'b0000, 4'b0100);
        if (obs_valid && obs_msg === tx[2]) vcnt++;
        cyc(4'b0000, 4'b0100);
        if (obs_valid && obs_msg === tx[2]) vcnt++;
        cyc(4'b0000, 4'b0000);
        chk("valid_len", 64'(vcnt), 64'd3);
        chk("valid_drop", 64'(obs_valid), 64'd0);
        cyc(4'b0000, 4'b0000);
        chk("release_gnt", 64'(obs_gnt), 64'd0);

        // Full contention: rotation 0,1,2,3,0 with a gap cycle between grants.
        reset_dut();
        for (int g = 0; g < 5; g++) begin
            cyc(4'b1111, 4'b0000);
            chk("rr_gap", 64'(obs_gnt), 64'd0);
            o = (m_owner >= 0) ? m_owner : 0;
            cyc(4'b1111, 4'b0001 << o);
            chk("rr_order", 64'(obs_owner), 64'(order[g]));
            cyc(4'b1111, 4'b0001 << o);
            cyc(4'b1111, 4'b0000);
        end

        // Owner keeps req after finishing: requester 3 must win next.
        reset_dut();
        cyc(4'b0010, 4'b0000);
        cyc(4'b0010, 4'b0010);
        cyc(4'b1010, 4'b0010);
        cyc(4'b1010, 4'b0000);
        cyc(4'b1010, 4'b0000);
        chk("rereq_gap", 64'(obs_gnt), 64'd0);
        cyc(4'b1010, 4'b0000);
        chk("rereq_gnt3", 64'(obs_gnt), 64'b1000);

        // Grant timeout: 16 cycles of grant, then drop with a sticky error.
        reset_dut();
        cyc(4'b0001, 4'b0000);
        hi = 0;
        repeat (16) begin
            cyc(4'b0001, 4'b0000);
            if (obs_gnt === 4'b0001) hi++;
        end
        chk("tmo_len", 64'(hi), 64'd16);
        cyc(4'b0000, 4'b0000);
        chk("tmo_drop", 64'(obs_gnt), 64'd0);
        chk("tmo_err", 64'(obs_err), 64'd1);
        repeat (3) cyc(4'b0000, 4'b0000);
        chk("tmo_sticky", 64'(obs_err), 64'd1);

        // Stray busy from a non-owner during a transfer.
        reset_dut();
        cyc(4'b0001, 4'b0000);
        cyc(4'b0001, 4'b0001);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0101);
        chk("stray_msg", 64'(obs_msg), 64'(tx[0]));
        cyc(4'b0000, 4'b0001);
        chk("stray_err", 64'(obs_err), 64'd1);
        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);

        // Asynchronous reset in the middle of a transfer.
        reset_dut();
        cyc(4'b0100, 4'b0000);
        cyc(4'b0100, 4'b0100);
        cyc(4'b0000, 4'b0100);
        req  = 4'b0000;
        busy = 4'b0100;
        #1;
        rst = 1'b0;
        #1;
        chk("arst_gnt",   64'(gnt),           64'd0);
        chk("arst_valid", 64'(req_bus_valid), 64'd0);
        chk("arst_owner", 64'(owner),         64'd0);
        @(posedge clk);
        #1;
        busy = 4'b0000;
        rst  = 1'b1;
        model_reset();
        cyc(4'b1010, 4'b0000);
        cyc(4'b1010, 4'b0000);
        chk("arst_first_gnt", 64'(obs_gnt), 64'b0010);

        // Randomized traffic with occasional stray busy pulses.
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            r_rand = 4'($urandom_range(0, 15));
            b_rand = 4'b0000;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) b_rand = 4'b0001 << m_owner;
            if ($urandom_range(0, 79) == 0) b_rand = b_rand | (4'b0001 << $urandom_range(0, 3));
            cyc(r_rand, b_rand);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/req_bus_arbiter.md
# req_bus_arbiter

Round-robin arbiter and broadcast mux for the shared snooping coherence request bus. Each requester is one cache port (icache or dcache of every core) using the existing `req`/`gnt`/`busy`/`tx` handshake. The arbiter owns the bus, grants one requester at a time, and drives the granted requester's message onto `req_bus_msg` for every cache to snoop. A second instance, with `resp_msg_t` retyped, serves the response bus.

## Interface
- `N_REQ`, default 4: number of requesters (2 cores × icache/dcache); must be ≥ 2.
- `GNT_TIMEOUT`, default 15: cycles a granted requester may take to raise `busy` before the grant is revoked; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
- `req`  in  N_REQ  per-requester bus request, level, held until granted.
- `busy`  in  N_REQ  per-requester transaction-in-progress; honoured only from the current owner.
- `tx`  in  N_REQ × req_msg_t  per-requester outgoing message.
- `gnt`  out  N_REQ  one-hot-or-zero grant.
- `req_bus_msg`  out  req_msg_t  broadcast message; `tx[owner]` when `req_bus_valid`, else all-zero.
- `req_bus_valid`  out  1  broadcast message valid this cycle.
- `owner`  out  $clog2(N_REQ)  index of current grantee; 0 when no grant.
- `arb_err`  out  1  sticky protocol error flag; cleared only by reset.

## Operation
- States: IDLE, GRANT, BUSY.
- IDLE:
  - `gnt` = 0.
  - If any `req` bit is set, pick the winner: the first set bit scanning upward from `last+1` modulo N_REQ.
  - Register `owner` = winner, set `gnt[winner]`, reset the timeout counter to 0, go to GRANT.
- GRANT:
  - `gnt[owner]` is held.
  - If `busy[owner]` = 1, go to BUSY.
  - Else if `req[owner]` = 0 (requester withdrew), go to IDLE and set `last` = owner.
  - Else increment the counter. When the counter reaches GNT_TIMEOUT, set `arb_err`, set `last` = owner, go to IDLE.
- BUSY:
  - `gnt[owner]` is held; `req_bus_valid` = `busy[owner]`.
  - When `busy[owner]` = 0, go to IDLE and set `last` = owner. The bus is valid in no cycle without `busy`.
- `busy` asserted by any non-owner in any state sets `arb_err` and is otherwise ignored.
- Simultaneous events:
  - Owner drops `busy` and keeps `req` in the same cycle: it re-enters arbitration in IDLE with lowest priority.
  - Several requests arriving together: exactly one grant per IDLE pass.
- Fairness: each active requester is granted within N_REQ arbitration rounds.
- Reset (including mid-transaction), asserted asynchronously:
  - State = IDLE, `gnt` = 0, `owner` = 0, `req_bus_valid` = 0, `req_bus_msg` = 0, `arb_err` = 0, counter = 0.
  - `last` = N_REQ-1, so requester 0 has first priority.

## Timing
- Grant latency: `req` seen high in an IDLE cycle → `gnt` high the next cycle (1 cycle). No grant is ever given in the same cycle as the request.
- `busy` seen while in GRANT → BUSY next cycle.
- `req_bus_msg` and `req_bus_valid` are combinational from `tx`/`busy` of the registered owner, with zero added latency. A snooper samples them at the same edge the owner sees `busy`.
- Release: `busy` falls → IDLE next cycle. This gives one turnaround cycle with `gnt` = 0 before any new grant, so the minimum back-to-back spacing is 2 cycles between grants.
- Timeout: `gnt` stays high for exactly GNT_TIMEOUT+1 cycles, then drops.
- `gnt`, `owner`, `arb_err`, state, `last` and the counter are all registers. The counter is $clog2(GNT_TIMEOUT+1) bits, saturating, never wraps.

## Structure
- Shared package `cache_types`: the existing `req_msg_t`/`resp_msg_t`; add the `arb_state_t` enum (ARB_IDLE, ARB_GRANT, ARB_BUSY) there.
- Sub-module `rr_picker` #(N): combinational. Inputs are the request vector and the `last` pointer; outputs are a `found` flag and the winner index. It uses double-width rotate-and-priority-encode and is reused by the response-bus instance.

## Test plan
- Single requester: `req`=4'b0100 → `gnt`=4'b0100 one cycle later. With `busy[2]` held 3 cycles and `tx[2]`=M, `req_bus_valid`=1 with `req_bus_msg`=M for exactly those 3 cycles; `gnt`=0 the cycle after `busy` falls.
- Contention: `req`=4'b1111 held, each owner holding `busy` 2 cycles → grant order 0,1,2,3,0, with one idle cycle between grants.
- Re-request: owner 1 drops `busy` while keeping `req`, and `req[3]`=1 → next grant goes to 3, not 1.
- Timeout: `req[0]`=1, `busy[0]` never rises, GNT_TIMEOUT=15 → `gnt[0]` high 16 cycles, then 0; `arb_err`=1 and stays 1.
- Illegal busy: owner 0 in BUSY, `busy[2]` pulsed → `arb_err`=1; `req_bus_msg` still equals `tx[0]`.
- Reset mid-BUSY: `rst`=0 asserted between edges → `gnt`, `req_bus_valid` and `owner` are 0 immediately, with no clock edge needed. After release with `req`=4'b1010, the first grant goes to 1.
